// File: rtl/pulse_period_monitor_if.sv
// pulse_period_monitor_if: pulse stream input, flag clear, and period/health outputs of the monitor
interface pulse_period_monitor_if #(
    parameter int CNT_W = 16
);
    logic             pulse_in;
    logic             clr;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [15:0]      pulse_count;
    logic             timeout;
    logic             early;
    logic             locked;

    modport master (
        output pulse_in, clr,
        input  period, period_valid, pulse_count, timeout, early, locked
    );

    modport slave (
        input  pulse_in, clr,
        output period, period_valid, pulse_count, timeout, early, locked
    );
endinterface

// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor: measures edge-to-edge pulse period, flags lost and early pulses; PULSE_PERIOD_MONITOR_SYNC_EN adds a 2-flop input synchronizer
module pulse_period_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000,
    parameter int MIN_GAP = 2
) (
    input logic clk,
    input logic rst,
    pulse_period_monitor_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOST    = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [15:0]      pulse_count;
    logic             timeout;
    logic             early;
    logic             pulse_s;
    logic             pulse_d;
    logic             rise;
    logic             at_limit;
    logic             set_to;
    logic             set_early;

`ifdef PULSE_PERIOD_MONITOR_SYNC_EN
    logic [1:0] sync;
    // two-flop synchronizer, reset high so a held-high input is not seen as an edge
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], bus.pulse_in};
    assign pulse_s = sync[1];
`else
    assign pulse_s = bus.pulse_in;
`endif

    assign rise      = pulse_s & ~pulse_d;
    assign at_limit  = cnt == CNT_W'(TIMEOUT - 1);
    assign set_to    = (state == MEASURE) && !rise && at_limit;
    assign set_early = (state == MEASURE) && rise && (cnt < CNT_W'(MIN_GAP));

    // previous input sample for rising-edge detection
    always_ff @(posedge clk or posedge rst)
        if (rst) pulse_d <= 1'b1;
        else     pulse_d <= pulse_s;

    // state, gap counter and period reporting
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            pulse_count  <= '0;
        end else begin
            period_valid <= (state == MEASURE) && rise;
            if (rise) pulse_count <= pulse_count + 16'd1;
            if ((state == MEASURE) && rise) period <= cnt;
            if (rise) begin
                state <= MEASURE;
                cnt   <= CNT_W'(1);
            end else if (state == MEASURE) begin
                if (at_limit) state <= LOST;
                else          cnt   <= cnt + CNT_W'(1);
            end
        end

    // sticky health flags; a set event outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            timeout <= 1'b0;
            early   <= 1'b0;
        end else begin
            timeout <= set_to    | (timeout & ~bus.clr);
            early   <= set_early | (early   & ~bus.clr);
        end

    assign bus.period       = period;
    assign bus.period_valid = period_valid;
    assign bus.pulse_count  = pulse_count;
    assign bus.timeout      = timeout;
    assign bus.early        = early;
    assign bus.locked       = state == MEASURE;
endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb_pulse_period_monitor: randomized and directed stimulus against a timestamp-based reference model with a period scoreboard
module tb_pulse_period_monitor;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int MIN_GAP = 4;
`ifdef PULSE_PERIOD_MONITOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int         n;
        logic [15:0] p;
    } exp_t;

    logic clk = 1'b1;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n     = 0;
    exp_t expq[$];
    exp_t e;

    int          last;
    logic        prev;
    logic        hist[$];
    logic [15:0] m_cnt;
    logic [15:0] m_per;
    logic        m_to;
    logic        m_early;
    logic        m_lock;

    pulse_period_monitor_if #(.CNT_W(CNT_W)) bus ();

    pulse_period_monitor #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT),
        .MIN_GAP(MIN_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at step %0d: got %0h want %0h", name, n, act, req);
        end
    endtask

    task automatic model_reset();
        last    = -1;
        prev    = 1'b1;
        hist    = {};
        for (int i = 0; i < LAT; i++) hist.push_back(1'b1);
        m_cnt   = '0;
        m_per   = '0;
        m_to    = 1'b0;
        m_early = 1'b0;
        m_lock  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("pulse_count", 32'(bus.pulse_count), 32'(m_cnt));
        chk("period",      32'(bus.period),      32'(m_per));
        chk("timeout",     32'(bus.timeout),     32'(m_to));
        chk("early",       32'(bus.early),       32'(m_early));
        chk("locked",      32'(bus.locked),      32'(m_lock));
    endtask

    task automatic step(input logic p, input logic c);
        logic s, r, rep, st, se;
        bus.pulse_in = p;
        bus.clr      = c;
        @(posedge clk);
        n++;
        if (rst) begin
            model_reset();
        end else begin
            hist.push_back(p);
            s    = hist.pop_front();
            r    = s && !prev;
            prev = s;
            rep  = r && last >= 0 && (n - last) <= TIMEOUT - 1;
            st   = !r && last >= 0 && (n - last) == TIMEOUT - 1;
            se   = rep && (n - last) < MIN_GAP;
            if (rep) begin
                m_per = 16'(n - last);
                expq.push_back('{n: n, p: m_per});
            end
            if (r) begin
                m_cnt = m_cnt + 16'd1;
                last  = n;
            end
            m_to    = st | (m_to & ~c);
            m_early = se | (m_early & ~c);
            m_lock  = last >= 0 && (n - last) < TIMEOUT - 1;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'b0);
    endtask

    // scoreboard: every strobe must match the oldest expected period in the same cycle
    always @(negedge clk) begin
        if (bus.period_valid) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL strobe at step %0d: got unexpected period %0d want none", n, bus.period);
            end else begin
                e = expq.pop_front();
                if (e.n != n || e.p !== bus.period) begin
                    bad++;
                    $display("FAIL strobe at step %0d: got period %0d want %0d at step %0d", n, bus.period, e.p, e.n);
                end
            end
        end else if (expq.size() > 0 && expq[0].n <= n) begin
            e = expq.pop_front();
            total++;
            bad++;
            $display("FAIL strobe missing at step %0d: got none want period %0d", n, e.p);
        end
    end

    initial begin
        int dens, len;
        rst          = 1'b1;
        bus.pulse_in = 1'b1;
        bus.clr      = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("valid_in_reset", 32'(bus.period_valid), 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #9;
        rst = 1'b0;
        repeat (4) step(1'b1, 1'b0);
        chk("held_high_no_edge", 32'(bus.pulse_count), 32'd0);

        idle(4);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            idle(9);
        end
        chk("five_pulses", 32'(bus.pulse_count), 32'd5);

        idle(80);
        step(1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b0);

        step(1'b0, 1'b1);
        idle(5);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        step(1'b1, 1'b0);
        idle(62);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);

        idle(3);
        step(1'b1, 1'b0);
        idle(4);
        rst = 1'b1;
        #1;
        expq = {};
        model_reset();
        check_outputs();
        chk("valid_async_rst", 32'(bus.period_valid), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(3);
        step(1'b1, 1'b0);
        idle(6);
        step(1'b1, 1'b0);

        for (int seg = 0; seg < 60; seg++) begin
            dens = $urandom_range(0, 3);
            len  = $urandom_range(5, 90);
            for (int i = 0; i < len; i++)
                step(dens != 0 && $urandom_range(0, dens * 4) == 0, $urandom_range(0, 15) == 0);
        end
        idle(2);

        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
